gray_seq_gen: RTL

GRAY_SEQ_GEN -- requirements
Module: gray_seq_gen

---
 rtl/gray_seq_gen.sv | 69 ++++++
 1 files changed

// File: rtl/gray_seq_gen.sv
// rtl/gray_seq_gen.sv - Gray-code sweep generator, ascending or descending, with pause
module gray_seq_gen #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             up,
    input  logic             pause,
    output logic [WIDTH-1:0] gray_out,
    output logic             valid,
    output logic             busy,
    output logic             done
);
    typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

    // count is one bit wider than idx so the full 2^WIDTH sweep is detected without relying on idx wrap
    localparam logic [WIDTH:0] LAST = {1'b1, {WIDTH{1'b0}}};

    state_t           state;
    logic [WIDTH-1:0] idx;
    logic [WIDTH:0]   count;
    logic             ascend;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            count    <= '0;
            ascend   <= 1'b1;
            gray_out <= '0;
            valid    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            valid <= 1'b0;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (start) begin
                        idx    <= up ? '0 : '1;
                        ascend <= up;
                        count  <= '0;
                        busy   <= 1'b1;
                        state  <= SWEEP;
                    end
                end
                SWEEP: begin
                    if (count == LAST) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (!pause) begin
                        gray_out <= idx ^ (idx >> 1);
                        valid    <= 1'b1;
                        idx      <= ascend ? idx + 1'b1 : idx - 1'b1;
                        count    <= count + 1'b1;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
